// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction fetch unit: state codes,
// default geometry and the opcode bit that marks a two-word instruction.
package busca_instrucao_pkg;

  localparam int          PC_WIDTH_PADRAO = 16;
  localparam logic [15:0] RESET_PC_PADRAO = 16'h0000;
  localparam int          BIT_LONGO       = 15;

  typedef enum logic [1:0] {
    BUSCA_OP  = 2'b00,
    BUSCA_IMM = 2'b01,
    ENTREGA   = 2'b10
  } estado_t;

  // An opcode word with the long-format bit set is followed by an immediate word.
  function automatic logic eh_longo(input logic [15:0] palavra);
    return palavra[BIT_LONGO];
  endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// Bundle of the memory port, redirect input and downstream handshake of
// the fetch unit. master = fetch unit side, slave = memory/decode side.
interface busca_instrucao_if #(
  parameter int PC_WIDTH = busca_instrucao_pkg::PC_WIDTH_PADRAO
);

  logic                mem_req;
  logic [PC_WIDTH-1:0] mem_addr;
  logic                mem_ack;
  logic [15:0]         mem_data;
  logic                desvio;
  logic [PC_WIDTH-1:0] alvo_desvio;
  logic                saida_valida;
  logic                saida_pronta;
  logic [15:0]         instrucao;
  logic [15:0]         imediato;
  logic [PC_WIDTH-1:0] pc_instrucao;

  modport master (
    output mem_req, mem_addr, saida_valida, instrucao, imediato, pc_instrucao,
    input  mem_ack, mem_data, desvio, alvo_desvio, saida_pronta
  );

  modport slave (
    input  mem_req, mem_addr, saida_valida, instrucao, imediato, pc_instrucao,
    output mem_ack, mem_data, desvio, alvo_desvio, saida_pronta
  );

endinterface

// File: rtl/busca_instrucao_contador_pc.sv
// Program counter: loadable wrap-around counter. A load wins over an
// increment; reset returns to the configured start address.
module contador_pc import busca_instrucao_pkg::*; #(
  parameter int                  PC_WIDTH = PC_WIDTH_PADRAO,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_PADRAO)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                carga_i,
  input  logic                incr_i,
  input  logic [PC_WIDTH-1:0] valor_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Next PC: load has priority, increment wraps modulo 2^PC_WIDTH.
  always_comb begin
    pc_d = pc_q;
    if (carga_i) begin
      pc_d = valor_i;
    end else if (incr_i) begin
      pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset to the start address.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: reads an opcode word and, for long-format
// opcodes, a following immediate word, then holds the result until the
// decode stage accepts it. A redirect restarts fetching at a new address.
module busca_instrucao import busca_instrucao_pkg::*; #(
  parameter int                  PC_WIDTH = PC_WIDTH_PADRAO,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_PADRAO)
) (
  input  logic              clock,
  input  logic              reset,
  busca_instrucao_if.master bus
);

  estado_t             estado_q, estado_d;
  logic [15:0]         instrucao_q, instrucao_d;
  logic [15:0]         imediato_q, imediato_d;
  logic [PC_WIDTH-1:0] pc_instrucao_q, pc_instrucao_d;
  logic                saida_valida_q, saida_valida_d;
  logic                carga_pc;
  logic                incr_pc;
  logic [PC_WIDTH-1:0] pc;

  contador_pc #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_contador_pc (
    .clock   (clock),
    .reset   (reset),
    .carga_i (carga_pc),
    .incr_i  (incr_pc),
    .valor_i (bus.alvo_desvio),
    .pc_o    (pc)
  );

  // Request is a pure decode of state; suppressed while reset is held.
  assign bus.mem_req  = ~reset & (estado_q != ENTREGA);
  assign bus.mem_addr = pc;

  // Next state, captured fields and PC control; a redirect overrides everything.
  always_comb begin
    estado_d       = estado_q;
    instrucao_d    = instrucao_q;
    imediato_d     = imediato_q;
    pc_instrucao_d = pc_instrucao_q;
    carga_pc       = 1'b0;
    incr_pc        = 1'b0;
    if (bus.desvio) begin
      carga_pc = 1'b1;
      estado_d = BUSCA_OP;
    end else begin
      case (estado_q)
        BUSCA_OP: begin
          if (bus.mem_ack) begin
            instrucao_d    = bus.mem_data;
            pc_instrucao_d = pc;
            incr_pc        = 1'b1;
            if (eh_longo(bus.mem_data)) begin
              estado_d = BUSCA_IMM;
            end else begin
              imediato_d = 16'h0000;
              estado_d   = ENTREGA;
            end
          end else begin
            estado_d = BUSCA_OP;
          end
        end
        BUSCA_IMM: begin
          if (bus.mem_ack) begin
            imediato_d = bus.mem_data;
            incr_pc    = 1'b1;
            estado_d   = ENTREGA;
          end else begin
            estado_d = BUSCA_IMM;
          end
        end
        ENTREGA: begin
          if (bus.saida_pronta) begin
            estado_d = BUSCA_OP;
          end else begin
            estado_d = ENTREGA;
          end
        end
        default: begin
          estado_d = BUSCA_OP;
        end
      endcase
    end
    saida_valida_d = (estado_d == ENTREGA);
  end

  // State and output registers; reset discards any in-flight fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= BUSCA_OP;
      instrucao_q    <= 16'h0000;
      imediato_q     <= 16'h0000;
      pc_instrucao_q <= {PC_WIDTH{1'b0}};
      saida_valida_q <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      instrucao_q    <= instrucao_d;
      imediato_q     <= imediato_d;
      pc_instrucao_q <= pc_instrucao_d;
      saida_valida_q <= saida_valida_d;
    end
  end

  assign bus.saida_valida = saida_valida_q;
  assign bus.instrucao    = instrucao_q;
  assign bus.imediato     = imediato_q;
  assign bus.pc_instrucao = pc_instrucao_q;

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 Parameter PC_WIDTH, default 16, memory address and PC width.
REQ-002 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  instruction-memory read request.
REQ-006 mem_addr  output  PC_WIDTH  word address of current request.
REQ-007 mem_ack  input  1  memory accepts request; mem_data valid this cycle.
REQ-008 mem_data  input  16  instruction-memory read word.
REQ-009 desvio  input  1  branch redirect pulse.
REQ-010 alvo_desvio  input  PC_WIDTH  redirect target address.
REQ-011 saida_valida  output  1  decoded fetch result available downstream.
REQ-012 saida_pronta  input  1  downstream (decode/extensor stage) ready.
REQ-013 instrucao  output  16  fetched opcode word.
REQ-014 imediato  output  16  immediate word, feeds the 16->32 sign extender.
REQ-015 pc_instrucao  output  PC_WIDTH  address of the opcode word.

Function
REQ-016 States: BUSCA_OP, BUSCA_IMM, ENTREGA; one-hot or binary, encoding from shared defs.
REQ-017 BUSCA_OP: mem_req=1, mem_addr=pc; on mem_ack capture instrucao<=mem_data, pc_instrucao<=pc, pc<=pc+1.
REQ-018 BUSCA_OP with mem_ack: mem_data[15]=1 -> BUSCA_IMM; else imediato<=16'h0000, -> ENTREGA.
REQ-019 BUSCA_IMM: mem_req=1, mem_addr=pc; on mem_ack imediato<=mem_data, pc<=pc+1, -> ENTREGA.
REQ-020 mem_req and mem_addr held stable until mem_ack sampled high; without ack, state unchanged.
REQ-021 ENTREGA: mem_req=0, saida_valida=1; instrucao, imediato, pc_instrucao held stable while saida_pronta=0.
REQ-022 Transfer = saida_valida & saida_pronta; on transfer -> BUSCA_OP next cycle; no fetch overlaps ENTREGA.
REQ-023 Latency with ack in request cycle: short instruction valid 1 cycle after op request; long, 2 cycles.
REQ-024 pc increments by 1 per accepted word, modulo 2^PC_WIDTH; long instruction at FFFF takes imm from 0000.
REQ-025 desvio=1 in any state: pc<=alvo_desvio, state<=BUSCA_OP, saida_valida=0 next cycle; mem_ack in that cycle ignored.
REQ-026 desvio abandons a pending request (mem_req may drop without ack); memory tolerates abandonment.
REQ-027 desvio and transfer in same cycle: transfer counts as completed; redirect still applies.
REQ-028 saida_valida never asserted in BUSCA_OP or BUSCA_IMM.

Reset
REQ-029 reset=1: state<=BUSCA_OP, pc<=RESET_PC, instrucao, imediato, pc_instrucao<=0, saida_valida<=0.
REQ-030 mem_req=0 in any cycle where reset=1; first request in cycle after reset deasserts.
REQ-031 reset mid-operation (pending request or ENTREGA) discards all in-flight data; desvio ignored while reset=1.

Structure
REQ-032 Shared defs file holds state codes, PC_WIDTH default, RESET_PC default, long-format bit index (15).
REQ-033 One sub-module contador_pc: loadable PC_WIDTH counter with reset value, increment and load (load priority).
REQ-034 All outputs registered except mem_req/mem_addr, which decode from state and pc.

Verification
REQ-035 Reset, memory acks immediately, mem[0]=16'h1234 -> mem_addr 0000, valid next cycle, instrucao 1234, imediato 0000, pc_instrucao 0000.
REQ-036 mem[2]=16'h8001, mem[3]=16'hFFFE -> two requests (0002,0003), instrucao 8001, imediato FFFE, next fetch at 0004.
REQ-037 Memory delays ack 3 cycles -> mem_addr/mem_req stable 4 cycles, single capture, no pc skip.
REQ-038 saida_pronta=0 for 5 cycles in ENTREGA -> outputs unchanged, mem_req=0 throughout; fetch resumes after ready.
REQ-039 desvio with alvo_desvio=16'h0040 during pending BUSCA_IMM -> ack ignored, valid low, next request at 0040.
REQ-040 pc=FFFF, mem[FFFF]=16'h8000, mem[0000]=16'h0007 -> imediato 0007, pc_instrucao FFFF, next fetch 0001.
